// File: rtl/rs_enc_ctrl_if.sv
// Stream and encoder-control bundle for rs_enc_ctrl.
// master = controller side, slave = source/sink/encoder side.
interface rs_enc_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [7:0] enc_x;
  logic       enc_enable;
  logic       enc_data;
  logic [7:0] enc_y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;

  modport master (
    input  in_valid, in_data, in_last, enc_y, out_ready,
    output in_ready, enc_x, enc_enable, enc_data,
           out_valid, out_data, out_sop, out_eop
  );

  modport slave (
    output in_valid, in_data, in_last, enc_y, out_ready,
    input  in_ready, enc_x, enc_enable, enc_data,
           out_valid, out_data, out_sop, out_eop
  );
endinterface

// File: rtl/rs_enc_ctrl.sv
// Codeword framing controller for the external 4-parity GF(2^8) RS encoder.
// Optional RS_ENC_CTRL_SHORTEN_EN: in_last closes the message phase early.
//
// state | meaning
// MSG   | accepting message symbols, encoder in message phase
// PAR   | shifting out NPAR parity symbols, input stalled
module rs_enc_ctrl #(
  parameter int MSG_LEN = 188,
  parameter int NPAR    = 4
) (
  input  logic clk,
  input  logic clrn,
  rs_enc_ctrl_if.master bus,
  output logic busy
);

  localparam int CW = $clog2(MSG_LEN + 4);
  localparam logic [CW-1:0] LAST_MSG = CW'(MSG_LEN - 1);
  localparam logic [CW-1:0] LAST_PAR = CW'(NPAR - 1);

  if (NPAR != 4) begin : g_npar_check
    $error("rs_enc_ctrl: NPAR must be 4 to match the encoder");
  end

  typedef enum logic {ST_MSG, ST_PAR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;
  logic          slot_free;
  logic          adv;
  logic          last_hit;

`ifdef RS_ENC_CTRL_SHORTEN_EN
  assign last_hit = bus.in_last;
`else
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
  assign last_hit = 1'b0;
`endif

  assign slot_free = !out_valid_q || bus.out_ready;
  assign adv       = slot_free && ((state_q == ST_PAR) || bus.in_valid);

  assign bus.in_ready   = (state_q == ST_MSG) && slot_free;
  assign bus.enc_x      = bus.in_data;
  assign bus.enc_data   = (state_q == ST_MSG);
  assign bus.enc_enable = adv;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_sop    = out_sop_q;
  assign bus.out_eop    = out_eop_q;
  assign busy           = (cnt_q != '0) || (state_q == ST_PAR);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_MSG;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    if (adv) begin
      out_data_d  = bus.enc_y;
      out_valid_d = 1'b1;
      out_sop_d   = (state_q == ST_MSG) && (cnt_q == '0);
      out_eop_d   = (state_q == ST_PAR) && (cnt_q == LAST_PAR);
      case (state_q)
        ST_MSG: begin
          if ((cnt_q == LAST_MSG) || last_hit) begin
            state_d = ST_PAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_PAR: begin
          // Encoder registers are all zero after the last parity shift,
          // so the next message can start on the following cycle.
          if (cnt_q == LAST_PAR) begin
            state_d = ST_MSG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_MSG;
          cnt_d   = '0;
        end
      endcase
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_enc_ctrl.sv
// Directed bench for rs_enc_ctrl with a behavioural RS(n,n-4) encoder and
// a polynomial-division parity model feeding an expected-symbol queue.
module tb_rs_enc_ctrl;
  localparam int ML = 188;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic busy;

  rs_enc_ctrl_if bus ();

  rs_enc_ctrl #(.MSG_LEN(ML), .NPAR(4)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.master),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return r;
  endfunction

  // External encoder: g(x) = x^4 + 0F x^3 + 36 x^2 + 78 x + 40
  logic [3:0][7:0] er;
  logic [7:0]      fb;
  assign fb        = bus.enc_data ? (bus.enc_x ^ er[3]) : 8'h00;
  assign bus.enc_y = bus.enc_data ? bus.enc_x : er[3];
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) er <= '0;
    else if (bus.enc_enable) begin
      er[3] <= er[2] ^ gmul(fb, 8'h0F);
      er[2] <= er[1] ^ gmul(fb, 8'h36);
      er[1] <= er[0] ^ gmul(fb, 8'h78);
      er[0] <= gmul(fb, 8'h40);
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0]  msg [0:ML-1];
  logic [7:0]  par [0:3];
  logic [9:0]  exq [$];
  bit          mon_en = 1'b1;
  bit          span_chk = 1'b0;
  int          span_exp = 191;
  bit          gap_act = 1'b0;
  bit          bp_en = 1'b0;
  logic [31:0] last4 = '0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic calc_par(input int n);
    logic [7:0] p [0:ML+3];
    logic [7:0] gc [1:4];
    logic [7:0] c;
    gc[1] = 8'h0F; gc[2] = 8'h36; gc[3] = 8'h78; gc[4] = 8'h40;
    for (int i = 0; i < ML + 4; i++) p[i] = 8'h00;
    for (int i = 0; i < n; i++) p[i] = msg[i];
    for (int i = 0; i < n; i++) begin
      c = p[i];
      for (int j = 1; j <= 4; j++) p[i+j] = p[i+j] ^ gmul(c, gc[j]);
    end
    for (int k = 0; k < 4; k++) par[k] = p[n+k];
  endtask

  task automatic push_exp(input int n);
    calc_par(n);
    for (int i = 0; i < n; i++) exq.push_back({(i == 0), 1'b0, msg[i]});
    for (int k = 0; k < 4; k++) exq.push_back({1'b0, (k == 3), par[k]});
  endtask

  task automatic send_msg(input int n, input int last_idx, input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps && i != 0 && (i % 10) == 0) begin
        bus.in_valid = 1'b0;
        gap_act = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        gap_act = 1'b0;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = msg[i];
      bus.in_last  = (i == last_idx);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.in_ready && t < 1000);
      if (!bus.in_ready) begin
        chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exq.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(exq.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Output monitor at the falling edge: scoreboard, hold stability, gap checks
  initial begin
    bit         hold_v;
    logic [9:0] hold_w;
    logic [9:0] w;
    int         sop_cyc;
    hold_v = 1'b0;
    hold_w = '0;
    sop_cyc = 0;
    forever begin
      @(negedge clk);
      if (gap_act) begin
        chk("gap_enable", 32'(bus.enc_enable), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
      end
      if (hold_v && clrn) chk("hold", {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data},
                              {1'b1, hold_w});
      hold_v = 1'b0;
      if (mon_en && clrn && bus.out_valid && bus.out_ready) begin
        chk("q_nonempty", 32'(exq.size() != 0), 32'd1);
        if (exq.size() != 0) begin
          w = exq.pop_front();
          chk("cw_sym", {bus.out_sop, bus.out_eop, bus.out_data}, w);
        end
        if (bus.out_sop) sop_cyc = cyc;
        if (bus.out_eop && span_chk) chk("span", 32'(cyc - sop_cyc), 32'(span_exp));
        last4 = {last4[23:0], bus.out_data};
      end
      if (bus.out_valid && !bus.out_ready) begin
        hold_v = 1'b1;
        hold_w = {bus.out_sop, bus.out_eop, bus.out_data};
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_sop_eop", {bus.out_sop, bus.out_eop}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_enc_data", 32'(bus.enc_data), 32'd1);
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // All-zero codeword, in_ready low for exactly the 4 parity cycles
    for (int i = 0; i < ML; i++) msg[i] = 8'h00;
    span_chk = 1'b1;
    span_exp = ML + 3;
    push_exp(ML);
    send_msg(ML, -1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("par_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    chk("post_par_in_ready", 32'(bus.in_ready), 32'd1);
    drain();
    chk("zero_parity", last4, 32'h0000_0000);
    chk("idle_busy", 32'(busy), 32'd0);

    // 0x01 then zeros, twice back-to-back
    msg[0] = 8'h01;
    push_exp(ML);
    push_exp(ML);
    send_msg(ML, -1, 1'b0);
    send_msg(ML, -1, 1'b0);
    drain();

    // Single trailing 0x01: parity is x^4 mod g(x)
    for (int i = 0; i < ML; i++) msg[i] = 8'h00;
    msg[ML-1] = 8'h01;
    push_exp(ML);
    send_msg(ML, -1, 1'b0);
    drain();
    chk("hand_parity", last4, 32'h0F36_7840);

    // Random message under random backpressure
    for (int i = 0; i < ML; i++) msg[i] = 8'($urandom_range(0, 255));
    span_chk = 1'b0;
    bp_en = 1'b1;
    push_exp(ML);
    send_msg(ML, -1, 1'b0);
    drain();
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Same message with 3-cycle input gaps every 10 symbols
    push_exp(ML);
    send_msg(ML, -1, 1'b1);
    drain();

    // Reset after 50 symbols discards the partial codeword
    mon_en = 1'b0;
    send_msg(50, -1, 1'b0);
    clrn = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    exq.delete();
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    span_chk = 1'b1;
    for (int i = 0; i < ML; i++) msg[i] = 8'($urandom_range(0, 255));
    push_exp(ML);
    send_msg(ML, -1, 1'b0);
    drain();

    // in_last on symbol 20
    for (int i = 0; i < ML; i++) msg[i] = 8'($urandom_range(0, 255));
`ifdef RS_ENC_CTRL_SHORTEN_EN
    span_exp = 23;
    push_exp(20);
    send_msg(20, 19, 1'b0);
`else
    span_exp = ML + 3;
    push_exp(ML);
    send_msg(ML, 19, 1'b0);
`endif
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_enc_ctrl.md
Name: rs_enc_ctrl

Overview:
- Sequencing controller for the 4-parity GF(2^8) RS encoder datapath (rs_enc): accepts a valid/ready message-symbol stream and frames it into codewords of MSG_LEN message symbols followed by 4 parity symbols.
- Drives the encoder's x/enable/data controls and registers the encoder output onto a valid/ready codeword stream with sop/eop markers.
- Sits between the packet source and the channel mapper; the encoder instance is external and shares clk/clrn.

Parameters:
- MSG_LEN, 188, message symbols per codeword (2..251); codeword length is MSG_LEN+4.
- NPAR, 4, parity symbols per codeword; fixed to match the encoder, any other value is a synthesis error.

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  asynchronous active-low reset; the same net also resets the encoder
- in_valid  in  1  message symbol valid
- in_ready  out  1  controller accepts the message symbol
- in_data  in  8  message symbol
- in_last  in  1  last message symbol (used only with the optional feature)
- enc_x  out  8  encoder symbol input
- enc_enable  out  1  encoder shift enable
- enc_data  out  1  1 = message phase, 0 = parity phase
- enc_y  in  8  encoder output (combinational from enc_x/enc_data)
- out_valid  out  1  codeword symbol valid
- out_ready  in  1  downstream accepts the symbol
- out_data  out  8  codeword symbol
- out_sop  out  1  first symbol of codeword
- out_eop  out  1  last parity symbol
- busy  out  1  codeword in progress (cnt != 0 or state == PAR)

Behaviour:
- States: MSG, PAR. Counter cnt with width clog2(MSG_LEN+4).
- Reset (async, clrn low): state=MSG, cnt=0, out_valid=0, out_data=0, out_sop=0, out_eop=0, busy=0.
- Output slot is free when (!out_valid || out_ready).
- adv = slot free && (state==PAR || in_valid).
- in_ready = (state==MSG) && slot free. Combinational; does not depend on in_valid.
- enc_x = in_data. enc_data = (state==MSG). enc_enable = adv.
- On adv: out_data <= enc_y; out_valid <= 1; out_sop <= (state==MSG && cnt==0); out_eop <= (state==PAR && cnt==NPAR-1).
- If the slot is free and there is no adv: out_valid <= 0.
- MSG: on each accepted symbol cnt++. When cnt==MSG_LEN-1 is accepted: go to PAR, cnt=0.
- PAR: advances every cycle the slot is free; no input is needed. On cnt==NPAR-1: go to MSG, cnt=0.
- Encoder registers self-clear: after 4 parity shifts (feedback=0) all encoder registers are 0, so no clear is needed between codewords. The next codeword may start on the cycle after the last parity advance (zero gap).
- Latency: a symbol is on out_data the cycle after its adv. Sustained throughput is 1 symbol/clk when out_ready=1 and in_valid=1.
- Backpressure: out_ready=0 with out_valid=1 holds out_data/sop/eop stable, deasserts enc_enable, and freezes the encoder and counters.
- in_valid low during MSG: no shift; the codeword stays open indefinitely.
- Reset mid-codeword: the partial codeword is discarded; the next accepted symbol starts a fresh codeword (sop=1).
- in_last is ignored when the optional feature is absent.

Optional Feature:
- Macro RS_ENC_CTRL_SHORTEN_EN.
- Defined: in_last=1 on an accepted MSG symbol ends the message phase early (shortened code): go to PAR, cnt=0, and emit 4 parity symbols. Reaching MSG_LEN without in_last still terminates normally.
- Not defined: in_last is unused; codewords are always MSG_LEN+4.

Test Plan:
- MSG_LEN=188, in_data=0x00 for 188 symbols, out_ready=1 -> 192 outputs, all 0x00. sop on output 1, eop on output 192, 192 consecutive valid cycles.
- Message 0x01 then 187x 0x00 -> out_data[0]=0x01 and the 4 parity symbols match the software RS(192,188) model. A second identical codeword sent back-to-back yields identical parity (self-clear check).
- Random message with out_ready toggling 50% -> output stream identical to the out_ready=1 run. out_data stable while out_valid && !out_ready. in_ready=0 throughout the 4 parity cycles.
- in_valid gaps of 3 cycles every 10 symbols -> no enc_enable during gaps; parity unchanged vs the gap-free run.
- clrn pulsed low after 50 symbols -> out_valid=0 and busy=0 immediately. A fresh 188-symbol codeword after release gives correct parity and sop.
- With RS_ENC_CTRL_SHORTEN_EN, in_last on symbol 20 -> 24-symbol codeword with eop on symbol 24, parity equal to the model with 168 leading zeros. Without the macro, in_last is ignored and the codeword is 192 symbols.
